// File: rtl/de_selector14_seq_if.sv
// rtl/de_selector14_seq_if.sv - bit-input handshake bundle for the 1-to-4 de-selector sequencer
//
// Purpose
//   Groups the upstream data-bit handshake and channel-enable mask of
//   de_selector14_seq into one bundle.
// Signals
//   iData   1  data bit to deliver
//   iValid  1  iData valid; transfer occurs when iValid && oReady at a rising edge
//   oReady  1  sequencer can accept a bit (driven combinationally by the sequencer)
//   iMask   4  channel enable, bit n = channel Zn; sampled only at acceptance
// Modports
//   master  producer side (drives iData/iValid/iMask, observes oReady)
//   slave   sequencer side

interface de_selector14_seq_if;
    logic       iData;
    logic       iValid;
    logic       oReady;
    logic [3:0] iMask;

    modport master (
        output iData,
        output iValid,
        output iMask,
        input  oReady
    );

    modport slave (
        input  iData,
        input  iValid,
        input  iMask,
        output oReady
    );
endinterface

// File: rtl/de_selector14_seq.sv
// rtl/de_selector14_seq.sv - round-robin sequencer driving a 1-to-4 de-selector
//
// Purpose
//   Accepts single data bits over a valid/ready handshake and routes each one
//   to the next enabled output channel (Z0..Z3) in round-robin order. Each bit
//   is held on oC for DWELL cycles with the select lines stable, followed by
//   GAP idle cycles where oC returns to IDLE_C and the selects keep their value.
// Parameters
//   DWELL   cycles each accepted bit is held on oC (1..255)
//   GAP     idle cycles after each dwell (0..255; 0 = no gap)
//   IDLE_C  level on oC when no bit is being delivered
// Ports
//   iCLK     in   1   clock, rising edge
//   iRST_N   in   1   asynchronous active-low reset
//   bus      slave    iData / iValid / oReady / iMask handshake bundle
//   oC       out  1   data to de-selector iC (registered)
//   oS1      out  1   select MSB (registered)
//   oS0      out  1   select LSB (registered)
//   oBusy    out  1   high while delivering a bit or in its gap (registered)
//   oDone    out  1   one-cycle pulse on the last dwell cycle of each bit (registered)
//   oCnt     out  32  per-channel 8-bit delivery counters {Z3,Z2,Z1,Z0}
//                     (present only when DESEL_SEQ_CNT_EN is defined)
// Configuration
//   DESEL_SEQ_CNT_EN  adds oCnt and the per-channel delivery counters

module de_selector14_seq #(
    parameter int   DWELL  = 4,
    parameter int   GAP    = 1,
    parameter logic IDLE_C = 1'b0
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    de_selector14_seq_if.slave      bus,
    output logic                    oC,
    output logic                    oS1,
    output logic                    oS0,
    output logic                    oBusy,
`ifdef DESEL_SEQ_CNT_EN
    output logic                    oDone,
    output logic [31:0]             oCnt
`else
    output logic                    oDone
`endif
);

    // Counter reload values; the counter always counts down to zero, so a
    // phase of N cycles is loaded with N-1.
    localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);
    localparam logic [7:0] GAP_M1   = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [1:0] ptr_q,   ptr_d;     // last channel that completed a delivery
    logic [1:0] sel_q,   sel_d;     // channel currently driven on {oS1,oS0}
    logic       c_q,     c_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;

    logic       ready;
    logic [1:0] next_ch;
    logic [1:0] idx;
    logic       found;

    assign ready      = (state_q == ST_IDLE) && (bus.iMask != 4'b0000);
    assign bus.oReady = ready;

    // Round-robin search starting just after the last served channel.
    // Offset 4 wraps back to ptr itself, so a mask holding only the last
    // served channel still selects it.
    always_comb begin
        next_ch = ptr_q + 2'd1;
        found   = 1'b0;
        idx     = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && bus.iMask[idx]) begin
                next_ch = idx;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        c_d     = c_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.iValid && ready) begin
                    c_d     = bus.iData;
                    sel_d   = next_ch;
                    busy_d  = 1'b1;
                    cnt_d   = DWELL_M1;
                    // oDone is registered, so it is set on the edge that
                    // enters the final dwell cycle.
                    done_d  = (DWELL_M1 == 8'd0);
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == 8'd0) begin
                    ptr_d = sel_q;
                    c_d   = IDLE_C;
                    if (GAP > 0) begin
                        cnt_d   = GAP_M1;
                        state_d = ST_GAP;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d  = cnt_q - 8'd1;
                    done_d = (cnt_q == 8'd1);
                end
            end
            ST_GAP: begin
                // Selects keep the last channel so the de-selector sees no glitch.
                if (cnt_q == 8'd0) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                c_d     = IDLE_C;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            ptr_q   <= 2'd3;       // first delivery lands on Z0
            sel_q   <= 2'd0;
            c_q     <= IDLE_C;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign oC    = c_q;
    assign oS1   = sel_q[1];
    assign oS0   = sel_q[0];
    assign oBusy = busy_q;
    assign oDone = done_q;

`ifdef DESEL_SEQ_CNT_EN
    logic [7:0] dcnt_q [4];

    // The channel being delivered is still on sel_q during the oDone cycle.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < 4; i++) begin
                dcnt_q[i] <= 8'd0;
            end
        end else if (done_q) begin
            dcnt_q[sel_q] <= dcnt_q[sel_q] + 8'd1;
        end
    end

    assign oCnt = {dcnt_q[3], dcnt_q[2], dcnt_q[1], dcnt_q[0]};
`endif

endmodule
